// File: rtl/serial_rx_deframer.sv
// Receive-side deframer: oversamples SerialIn, recovers start/8 data/parity/stop frames,
// and reports each frame as a good byte, a parity error or a framing error.
module serial_rx_deframer #(
    parameter int BIT_CYCLES = 16,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic       CLOCK_50,
    input  logic       resetN,
    input  logic       SerialIn,
    output logic [7:0] Dout,
    output logic       valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy,
    output logic [2:0] state_dbg
);

    localparam int CW = $clog2(BIT_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(BIT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(BIT_CYCLES / 2 - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        PARITY  = 3'd3,
        STOP    = 3'd4,
        WAIT_HI = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic            sync1_q, s_in_q;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            pok_q, pok_d;
    logic [7:0]      dout_q, dout_d;
    logic            valid_q, valid_d;
    logic            parity_err_q, parity_err_d;
    logic            frame_err_q, frame_err_d;
    logic            busy_q, busy_d;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        shift_d      = shift_q;
        pok_d        = pok_q;
        dout_d       = dout_q;
        valid_d      = 1'b0;
        parity_err_d = 1'b0;
        frame_err_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (!s_in_q) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                // Half-bit check rejects glitches and aligns later samples to mid-bit.
                if (cnt_q == CNT_HALF) begin
                    cnt_d = '0;
                    if (s_in_q) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DATA;
                        idx_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {s_in_q, shift_q[7:1]};
                    if (idx_q == 3'd7) begin
                        state_d = PARITY;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PARITY: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    pok_d   = ((^shift_q) ^ s_in_q) == PARITY_ODD;
                    state_d = STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (s_in_q) begin
                        state_d = IDLE;
                        if (pok_q) begin
                            dout_d  = shift_q;
                            valid_d = 1'b1;
                        end else begin
                            parity_err_d = 1'b1;
                        end
                    end else begin
                        // A low stop bit may be a line break; wait for idle before rearming.
                        frame_err_d = 1'b1;
                        state_d     = WAIT_HI;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_HI: begin
                if (s_in_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLOCK_50 or negedge resetN) begin
        if (!resetN) begin
            sync1_q      <= 1'b1;
            s_in_q       <= 1'b1;
            state_q      <= IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            shift_q      <= '0;
            pok_q        <= 1'b0;
            dout_q       <= '0;
            valid_q      <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            sync1_q      <= SerialIn;
            s_in_q       <= sync1_q;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shift_q      <= shift_d;
            pok_q        <= pok_d;
            dout_q       <= dout_d;
            valid_q      <= valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            busy_q       <= busy_d;
        end
    end

    assign Dout       = dout_q;
    assign valid      = valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign busy       = busy_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_serial_rx_deframer.sv
// Randomized bench for serial_rx_deframer: frames are scored by a frame-level reference
// model and checked for kind, byte value and latency as the strobes appear.
module tb_serial_rx_deframer;

    localparam int BC      = 16;
    localparam bit POD     = 1'b0;
    localparam int LATENCY = BC / 2 + 10 * BC + 3;

    logic       CLOCK_50;
    logic       resetN;
    logic       SerialIn;
    logic [7:0] Dout;
    logic       valid;
    logic       parity_err;
    logic       frame_err;
    logic       busy;
    logic [2:0] state_dbg;

    serial_rx_deframer #(.BIT_CYCLES(BC), .PARITY_ODD(POD)) dut (
        .CLOCK_50   (CLOCK_50),
        .resetN     (resetN),
        .SerialIn   (SerialIn),
        .Dout       (Dout),
        .valid      (valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .busy       (busy),
        .state_dbg  (state_dbg)
    );

    // clock / reset
    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    int cyc = 0;
    always @(posedge CLOCK_50) cyc <= cyc + 1;

    // scoreboard: {kind[1:0], dout[7:0], due_cycle[31:0]}; kind 0=valid 1=parity 2=frame
    logic [41:0] exp_q[$];
    logic [7:0]  model_dout = 8'h00;
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // driver tasks; all start and end on a falling edge
    task automatic drive_bit(input logic b);
        SerialIn = b;
        repeat (BC) @(negedge CLOCK_50);
    endtask

    task automatic idle(input int n);
        SerialIn = 1'b1;
        repeat (n) @(negedge CLOCK_50);
    endtask

    // Reference model: the whole frame is judged from its data, parity and stop bit.
    task automatic send_frame(input logic [7:0] data, input bit bad_par, input logic stop_bit);
        logic       par;
        int         ones;
        logic [1:0] kind;
        logic [7:0] edout;
        par  = (POD ? ~(^data) : (^data)) ^ bad_par;
        ones = $countones(data) + int'(par);
        if (stop_bit == 1'b0) begin
            kind  = 2'd2;
            edout = model_dout;
        end else if ((ones % 2) == int'(POD)) begin
            kind       = 2'd0;
            model_dout = data;
            edout      = data;
        end else begin
            kind  = 2'd1;
            edout = model_dout;
        end
        exp_q.push_back({kind, edout, 32'(cyc + 1 + LATENCY)});
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(data[i]);
        drive_bit(par);
        drive_bit(stop_bit);
    endtask

    // monitor
    always @(negedge CLOCK_50) begin
        if (resetN && (valid || parity_err || frame_err)) begin
            logic [41:0] e;
            logic [1:0]  kind_act;
            int          due;
            check("strobe_onehot", 32'(int'(valid) + int'(parity_err) + int'(frame_err)), 32'd1);
            kind_act = valid ? 2'd0 : (parity_err ? 2'd1 : 2'd2);
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_strobe: got kind %0d with no frame pending (cycle %0d)", kind_act, cyc);
            end else begin
                e = exp_q.pop_front();
                check("strobe_kind", 32'(kind_act), 32'(e[41:40]));
                check("dout", 32'(Dout), 32'(e[39:32]));
                due = int'(e[31:0]);
                n_checks++;
                if (cyc >= due - 1 && cyc <= due + 1) n_pass++;
                else $display("FAIL latency: got cycle %0d expected %0d +/-1", cyc, due);
            end
        end
    end

    initial begin
        resetN   = 1'b0;
        SerialIn = 1'b1;
        repeat (4) @(negedge CLOCK_50);
        check("rst_dout", 32'(Dout), 32'h00);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_parity_err", 32'(parity_err), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        resetN = 1'b1;
        idle(5);

        // bad parity straight after reset: Dout must stay 00
        send_frame(8'hA5, 1'b1, 1'b1);
        idle(8);
        check("perr_dout_hold", 32'(Dout), 32'h00);
        send_frame(8'hA5, 1'b0, 1'b1);
        idle(8);
        check("good_dout", 32'(Dout), 32'hA5);

        // framing error with the line held low, then released
        send_frame(8'h3C, 1'b0, 1'b0);
        repeat (40) @(negedge CLOCK_50);
        check("break_busy", 32'(busy), 32'd1);
        SerialIn = 1'b1;
        repeat (5) @(negedge CLOCK_50);
        check("break_release_busy", 32'(busy), 32'd0);
        idle(10);

        // 4-clock glitch: no strobe, busy returns low promptly
        SerialIn = 1'b0;
        repeat (4) @(negedge CLOCK_50);
        check("glitch_busy_hi", 32'(busy), 32'd1);
        SerialIn = 1'b1;
        repeat (BC / 2 + 2) @(negedge CLOCK_50);
        check("glitch_busy_lo", 32'(busy), 32'd0);
        idle(10);

        // reset during data bit 3 of 0x55
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        SerialIn = 1'b0;
        repeat (BC / 2) @(negedge CLOCK_50);
        resetN   = 1'b0;
        SerialIn = 1'b1;
        repeat (3) @(negedge CLOCK_50);
        model_dout = 8'h00;
        check("midrst_dout", 32'(Dout), 32'h00);
        check("midrst_busy", 32'(busy), 32'd0);
        resetN = 1'b1;
        idle(5);
        send_frame(8'h3C, 1'b0, 1'b1);
        idle(8);

        // back-to-back frames, zero idle gap
        send_frame(8'h00, 1'b0, 1'b1);
        send_frame(8'hFF, 1'b0, 1'b1);
        idle(8);
        check("b2b_last_dout", 32'(Dout), 32'hFF);

        // random traffic
        for (int n = 0; n < 30; n++) begin
            logic [7:0] d;
            bit         bp;
            logic       sb;
            d  = 8'($urandom_range(0, 255));
            bp = ($urandom_range(0, 3) == 0);
            sb = ($urandom_range(0, 7) != 0);
            send_frame(d, bp, sb);
            if (!sb) idle(BC + $urandom_range(0, 10));
            else     idle($urandom_range(0, 20));
        end

        for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(negedge CLOCK_50);
        while (exp_q.size() != 0) begin
            logic [41:0] e;
            e = exp_q.pop_front();
            n_checks++;
            $display("FAIL missing_strobe: got none expected kind %0d dout %0h", e[41:40], e[39:32]);
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
